// File: rtl/dm_pkg.sv
// Shared DM definitions: access-size encodings, store-buffer entry type and load extraction.
package dm_pkg;

  localparam int unsigned DM_AW   = 32;
  localparam int unsigned DM_DW   = 32;
  localparam int unsigned DM_SELW = 3;

  localparam logic [1:0] DMSEL_BYTE = 2'b00;
  localparam logic [1:0] DMSEL_HALF = 2'b01;
  localparam logic [1:0] DMSEL_WORD = 2'b10;
  localparam int unsigned DMSEL_ZEXT_BIT = 2;

  typedef struct packed {
    logic [DM_SELW-1:0] sel;
    logic [DM_AW-1:0]   addr;
    logic [DM_DW-1:0]   data;
  } sb_entry_t;

  // Select byte/half lane from a word and sign- or zero-extend; word size passes through.
  function automatic logic [DM_DW-1:0] dm_extract(input logic [DM_DW-1:0]   d,
                                                  input logic [DM_SELW-1:0] sel,
                                                  input logic [1:0]         off);
    logic [DM_DW-1:0] sh;
    logic [7:0]       b;
    logic [15:0]      h;
    logic             zext;
    sh   = d >> {off, 3'b000};
    b    = sh[7:0];
    h    = off[1] ? d[31:16] : d[15:0];
    zext = sel[DMSEL_ZEXT_BIT];
    if (sel[1]) begin
      return d;
    end else if (sel[0]) begin
      return zext ? {16'h0000, h} : {{16{h[15]}}, h};
    end else begin
      return zext ? {24'h000000, b} : {{24{b[7]}}, b};
    end
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// MEM-stage request bus into the store buffer, with stall/read-data/empty responses.
interface dm_store_buffer_if;
  logic        ReqValid;
  logic        ReqWE;
  logic [2:0]  ReqSel;
  logic [31:0] ReqA;
  logic [31:0] ReqD;
  logic        Stall;
  logic [31:0] RData;
  logic        Empty;

  modport master (
    output ReqValid, ReqWE, ReqSel, ReqA, ReqD,
    input  Stall, RData, Empty
  );

  modport slave (
    input  ReqValid, ReqWE, ReqSel, ReqA, ReqD,
    output Stall, RData, Empty
  );
endinterface

// File: rtl/dm_sb_fifo.sv
// Store-buffer entry FIFO: storage, head/tail pointers, occupancy and per-entry hit info.
// With DM_STORE_BUFFER_FWD_EN it also resolves the youngest matching entry.
module dm_sb_fifo
  import dm_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_i,
  input  sb_entry_t              enq_ent_i,
  input  logic                   deq_i,
  output logic [CW-1:0]          count_o,
  output sb_entry_t              head_ent_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH-1:0][29:0] waddr_o
`ifdef DM_STORE_BUFFER_FWD_EN
  ,
  input  logic [DEPTH-1:0]       match_i,
  output logic                   young_word_o,
  output logic [DM_DW-1:0]       young_data_o
`endif
);

  sb_entry_t         mem_q [DEPTH];
  sb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rel;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (enq_i) begin
      mem_d[tail_q] = enq_ent_i;
      tail_d        = tail_q + PW'(1);
    end
    if (deq_i) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(enq_i) - CW'(deq_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; liveness comes from the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // An entry is live when its distance from head (mod DEPTH) is below the count.
  always_comb begin
    valid_o = '0;
    waddr_o = '0;
    rel     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel        = PW'(i) - head_q;
      valid_o[i] = CW'(rel) < count_q;
      waddr_o[i] = mem_q[i].addr[31:2];
    end
  end

  assign count_o    = count_q;
  assign head_ent_o = mem_q[head_q];

`ifdef DM_STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;
  logic [PW-1:0] young_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    idx       = '0;
    young_idx = head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (match_i[idx]) begin
        young_idx = idx;
      end
    end
  end

  assign young_word_o = mem_q[young_idx].sel[1];
  assign young_data_o = mem_q[young_idx].data;
`endif

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer between MEM-stage requests and DM; loads own the DM port, stores drain
// when it is free. Optional store-to-load forwarding of word entries: DM_STORE_BUFFER_FWD_EN.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                RESET,
  dm_store_buffer_if.slave    req,
  output logic                DM_WE,
  output logic [DM_SELW-1:0]  DM_Sel,
  output logic [DM_AW-1:0]    DM_A,
  output logic [DM_DW-1:0]    DM_D,
  input  logic [DM_DW-1:0]    DM_Q
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]          count;
  sb_entry_t              head_ent;
  sb_entry_t              enq_ent;
  logic [DEPTH-1:0]       valid_vec;
  logic [DEPTH-1:0]       match_vec;
  logic [DEPTH-1:0][29:0] waddr;
  logic                   is_load;
  logic                   is_store;
  logic                   hit;
  logic                   fwd_ok;
  logic [DM_DW-1:0]       fwd_rdata;
  logic                   load_port;
  logic                   full;
  logic                   drain;
  logic                   enq;
  logic [DM_DW-1:0]       rdata;

  assign is_load  = req.ReqValid & ~req.ReqWE;
  assign is_store = req.ReqValid &  req.ReqWE;

  always_comb begin
    enq_ent      = '0;
    enq_ent.sel  = req.ReqSel;
    enq_ent.addr = req.ReqA;
    enq_ent.data = req.ReqD;
  end

  // Word-granular overlap of the request against every live entry.
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_vec[i] & (waddr[i] == req.ReqA[31:2]);
    end
  end

  assign hit       = is_load & (|match_vec);
  assign load_port = is_load & ~hit;
  assign full      = (count == CW'(DEPTH));
  assign drain     = ~RESET & (count != '0) & ~load_port;
  assign enq       = ~RESET & is_store & ~full;

`ifdef DM_STORE_BUFFER_FWD_EN
  logic             young_word;
  logic [DM_DW-1:0] young_data;

  assign fwd_ok    = hit & young_word;
  assign fwd_rdata = dm_extract(young_data, req.ReqSel, req.ReqA[1:0]);
`else
  assign fwd_ok    = 1'b0;
  assign fwd_rdata = '0;
`endif

  dm_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (RESET),
    .enq_i      (enq),
    .enq_ent_i  (enq_ent),
    .deq_i      (drain),
    .count_o    (count),
    .head_ent_o (head_ent),
    .valid_o    (valid_vec),
    .waddr_o    (waddr)
`ifdef DM_STORE_BUFFER_FWD_EN
    ,
    .match_i      (match_vec),
    .young_word_o (young_word),
    .young_data_o (young_data)
`endif
  );

  // DM port owner: a non-hitting load first, otherwise the FIFO head, otherwise idle zeros.
  always_comb begin
    DM_WE  = 1'b0;
    DM_Sel = '0;
    DM_A   = '0;
    DM_D   = '0;
    if (!RESET) begin
      if (load_port) begin
        DM_Sel = req.ReqSel;
        DM_A   = req.ReqA;
      end else if (drain) begin
        DM_WE  = 1'b1;
        DM_Sel = head_ent.sel;
        DM_A   = head_ent.addr;
        DM_D   = head_ent.data;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!RESET) begin
      if (load_port) begin
        rdata = DM_Q;
      end else if (fwd_ok) begin
        rdata = fwd_rdata;
      end
    end
  end

  assign req.RData = rdata;
  assign req.Stall = ~RESET & ((hit & ~fwd_ok) | (is_store & full));
  assign req.Empty = RESET | (count == '0);

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus random traffic against a
// queue-based reference model with a word-array DM.
module tb_dm_store_buffer;
  import dm_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef DM_STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_we;
  logic [2:0]  dm_sel;
  logic [31:0] dm_a;
  logic [31:0] dm_d;
  logic [31:0] dm_q;
  logic [31:0] dm_mem [64];

  int checks = 0;
  int errors = 0;
  st_t q[$];

  dm_store_buffer_if bus ();

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .RESET  (rst),
    .req    (bus),
    .DM_WE  (dm_we),
    .DM_Sel (dm_sel),
    .DM_A   (dm_a),
    .DM_D   (dm_d),
    .DM_Q   (dm_q)
  );

  always #5 clk = ~clk;

  assign dm_q = dm_mem[dm_a[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_extract(logic [31:0] d, logic [2:0] sel, logic [1:0] off);
    logic [31:0] v;
    if (sel[1]) return d;
    if (sel[0]) begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (!sel[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = (d >> (8 * off)) & 32'hFF;
      if (!sel[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic dm_write(input st_t e);
    logic [31:0] w;
    w = dm_mem[e.a[7:2]];
    if (e.sel[1]) w = e.d;
    else if (e.sel[0]) w[16 * e.a[1] +: 16] = e.d[15:0];
    else w[8 * e.a[1:0] +: 8] = e.d[7:0];
    dm_mem[e.a[7:2]] = w;
  endtask

  // One clock of stimulus: drive, compare against the model, then advance the model.
  task automatic step(input bit r, input bit v, input bit we, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] d, output bit stalled);
    bit e_stall, e_we, e_empty, hit, drain, push;
    logic [31:0] e_rdata, e_a, e_d;
    logic [2:0]  e_sel;
    int yi;
    st_t ne;
    @(negedge clk);
    rst = r; bus.ReqValid = v; bus.ReqWE = we; bus.ReqSel = sel; bus.ReqA = a; bus.ReqD = d;
    #1;
    e_stall = 0; e_we = 0; e_rdata = '0; e_a = '0; e_d = '0; e_sel = '0;
    drain = 0; push = 0; hit = 0; yi = -1;
    e_empty = r || (q.size() == 0);
    if (!r) begin
      foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin hit = 1; yi = i; end
      if (v && !we && !hit) begin
        e_sel = sel; e_a = a; e_rdata = dm_mem[a[7:2]];
      end else begin
        if (v && !we) begin
          if (FWD && q[yi].sel[1]) e_rdata = ref_extract(q[yi].d, sel, a[1:0]);
          else e_stall = 1;
        end
        if (v && we) begin
          if (q.size() == DEPTH) e_stall = 1;
          else push = 1;
        end
        if (q.size() > 0) begin
          drain = 1; e_we = 1; e_sel = q[0].sel; e_a = q[0].a; e_d = q[0].d;
        end
      end
    end
    chk("stall", 32'(bus.Stall), 32'(e_stall));
    chk("rdata", bus.RData, e_rdata);
    chk("empty", 32'(bus.Empty), 32'(e_empty));
    chk("dm_we", 32'(dm_we), 32'(e_we));
    chk("dm_sel", 32'(dm_sel), 32'(e_sel));
    chk("dm_a", dm_a, e_a);
    chk("dm_d", dm_d, e_d);
    stalled = e_stall;
    if (r) begin
      q.delete();
    end else begin
      if (drain) begin
        dm_write(q[0]);
        void'(q.pop_front());
      end
      if (push) begin
        ne.sel = sel; ne.a = a; ne.d = d;
        q.push_back(ne);
      end
    end
  endtask

  // Re-issue a request until the model says it is serviced; overrunning the bound is a failure.
  task automatic hold(input bit we, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    bit s;
    int n;
    n = 0;
    do begin
      step(0, 1, we, sel, a, d, s);
      n++;
    end while (s && n < 3 * DEPTH + 4);
    checks++;
    if (s) begin
      errors++;
      $error("FAIL hold_bound got=stalled exp=serviced a=%h", a);
    end
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000, $urandom, $urandom, s);
  endtask

  initial begin
    bit s;
    bit rv, rw, rr;
    logic [2:0]  rsel;
    logic [31:0] ra;
    for (int i = 0; i < 64; i++) dm_mem[i] = $urandom;
    rst = 1; bus.ReqValid = 0; bus.ReqWE = 0; bus.ReqSel = '0; bus.ReqA = '0; bus.ReqD = '0;

    step(1, 0, 0, 3'b000, 0, 0, s);
    step(1, 1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, s);

    // Store then idle.
    step(0, 1, 1, 3'b010, 32'h10, 32'h1234_5678, s);
    idle(2);

    // Stores interleaved with port-owning loads.
    for (int k = 0; k < 5; k++) begin
      hold(1, 3'b010, 32'h80 + 32'(4 * k), $urandom);
      step(0, 1, 0, 3'b010, 32'hC0, 0, s);
    end
    idle(DEPTH + 1);

    // Byte store followed by overlapping zero-extended byte load.
    step(0, 1, 1, 3'b000, 32'h21, 32'h0000_00AB, s);
    hold(0, 3'b100, 32'h23, 0);
    step(0, 1, 0, 3'b100, 32'h21, 0, s);

    // Non-overlapping load takes the port; drain follows.
    idle(DEPTH + 1);
    step(0, 1, 1, 3'b010, 32'h40, 32'hCAFE_0001, s);
    step(0, 1, 0, 3'b010, 32'h80, 0, s);
    idle(2);

    // Word store then overlapping signed half load.
    step(0, 1, 1, 3'b010, 32'h30, 32'hFFFF_8001, s);
    hold(0, 3'b001, 32'h32, 0);
    idle(2);

    // Reset with a store pending and another presented; neither may reach DM.
    step(0, 1, 1, 3'b010, 32'h50, 32'h5555_5555, s);
    step(0, 1, 0, 3'b010, 32'hA0, 0, s);
    step(1, 1, 1, 3'b010, 32'h54, 32'h6666_6666, s);
    idle(3);
    step(0, 1, 0, 3'b010, 32'h50, 0, s);
    step(0, 1, 0, 3'b010, 32'h54, 0, s);

    // Random traffic, occasional reset.
    for (int n = 0; n < 600; n++) begin
      rr   = ($urandom_range(0, 99) < 2);
      rv   = ($urandom_range(0, 99) < 75);
      rw   = $urandom_range(0, 1);
      rsel = 3'($urandom_range(0, 7));
      ra   = 32'($urandom_range(0, 255));
      if (rsel[1]) ra[1:0] = 2'b00;
      else if (rsel[0]) ra[0] = 1'b0;
      step(rr, rv, rw, rsel, ra, $urandom, s);
    end
    idle(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
